// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg: shared types, defaults and width helpers for the button event scheduler
package btn_sched_pkg;
  localparam int NUM_BTNS_DEF = 4;
  localparam int TS_WIDTH_DEF = 16;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
  // Index width never collapses to zero, so a 1-lane or 1-count field stays legal.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search for the first request after the last grant
// Ports: req (request vector), last (previous winner), gnt_valid (any request), gnt_idx (winner)
module rr_arbiter
  import btn_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  // Scanning from the farthest candidate down lets the nearest one after last overwrite the rest.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx = IDX_W'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler: turns button presses into timestamped events on one valid/ready stream
// Ports: clk, rst (async, active-high); btn_level (debounced levels);
//        evt_valid/evt_ready/evt_lane/evt_time (event stream); pending (occupied slots);
//        overrun (sticky dropped-press flag) and clr_overrun (its synchronous clear)
module btn_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int NUM_BTNS = NUM_BTNS_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int TICK_DIV = 50000,
  localparam int IDX_W = idx_w(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_lane,
  output logic [TS_WIDTH-1:0] evt_time,
  output logic [NUM_BTNS-1:0] pending,
  output logic                overrun,
  input  logic                clr_overrun
);
  localparam int PW = idx_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  logic [PW-1:0]       r_pre;
  logic [TS_WIDTH-1:0] r_ts;
  logic [NUM_BTNS-1:0] r_prev;
  logic [NUM_BTNS-1:0] r_pend;
  logic [TS_WIDTH-1:0] r_stamp [NUM_BTNS];
  state_t              r_state;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_lane;
  logic [TS_WIDTH-1:0] r_time;
  logic                r_ovr;
  logic [NUM_BTNS-1:0] w_rise;
  logic                w_gnt_valid;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_do_grant;
  logic [NUM_BTNS-1:0] w_gnt_mask;
  logic [NUM_BTNS-1:0] w_capture;
  rr_arbiter #(.N(NUM_BTNS)) u_arb (
    .req       (r_pend),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );
  assign w_rise = btn_level & ~r_prev;
  assign w_do_grant = w_gnt_valid & ((r_state == EMPTY) | evt_ready);
  assign w_gnt_mask = w_do_grant ? (NUM_BTNS'(1) << w_gnt_idx) : '0;
  // A slot being granted this cycle is free to take a new press in the same cycle.
  assign w_capture = w_rise & (~r_pend | w_gnt_mask);
  assign evt_valid = (r_state == FULL);
  assign evt_lane = r_lane;
  assign evt_time = r_time;
  assign pending = r_pend;
  assign overrun = r_ovr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_ts <= '0;
      r_prev <= '0;
      r_pend <= '0;
      for (int i = 0; i < NUM_BTNS; i++) r_stamp[i] <= '0;
      r_state <= EMPTY;
      r_last <= IDX_W'(NUM_BTNS - 1);
      r_lane <= '0;
      r_time <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
      r_ts <= (r_pre == PRE_MAX) ? r_ts + 1'b1 : r_ts;
      r_prev <= btn_level;
      r_pend <= (r_pend & ~w_gnt_mask) | w_rise;
      for (int i = 0; i < NUM_BTNS; i++) if (w_capture[i]) r_stamp[i] <= r_ts;
      if (w_do_grant) begin
        r_state <= FULL;
        r_lane <= w_gnt_idx;
        r_time <= r_stamp[w_gnt_idx];
        r_last <= w_gnt_idx;
      end else if (evt_ready) begin
        r_state <= EMPTY;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      r_ovr <= (|(w_rise & ~w_capture)) | (r_ovr & ~clr_overrun);
    end
  end
endmodule

// File: tb/tb_btn_event_scheduler.sv
// tb_btn_event_scheduler: randomized and directed scoreboard bench for btn_event_scheduler
module tb_btn_event_scheduler;
  localparam int N = 4;
  localparam int TW = 4;
  localparam int TD = 2;
  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn_level;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_lane;
  logic [TW-1:0] evt_time;
  logic [N-1:0]  pending;
  logic          overrun;
  logic          clr_overrun;
  int n_chk = 0;
  int n_fail = 0;
  bit [N-1:0] m_pend, m_prev;
  int m_stamp [N];
  int m_last, m_c, m_lane, m_time;
  bit m_full, m_ovr;
  int q[$];
  btn_event_scheduler #(.NUM_BTNS(N), .TS_WIDTH(TW), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_lane    (evt_lane),
    .evt_time    (evt_time),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_pend = '0;
    m_prev = '0;
    for (int i = 0; i < N; i++) m_stamp[i] = 0;
    m_last = N - 1;
    m_c = 0;
    m_full = 0;
    m_ovr = 0;
    m_lane = 0;
    m_time = 0;
    q.delete();
  endtask
  // Reference: what the next clock edge does, expressed as event rules on plain arrays.
  task automatic m_step(input bit [N-1:0] lvl, input bit rdy, input bit clr);
    int ts, w, j;
    bit set;
    ts = (m_c / TD) % (1 << TW);
    w = -1;
    set = 0;
    if (!m_full || rdy)
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (w < 0 && m_pend[j]) w = j;
      end
    if (w >= 0) begin
      m_lane = w;
      m_time = m_stamp[w];
      q.push_back(w * 256 + m_stamp[w]);
      m_last = w;
      m_full = 1;
      m_pend[w] = 0;
    end else if (rdy) m_full = 0;
    for (int i = 0; i < N; i++)
      if (lvl[i] && !m_prev[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1;
          m_stamp[i] = ts;
        end else set = 1;
      end
    m_ovr = set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_prev = lvl;
    m_c++;
  endtask
  task automatic cyc(input bit [N-1:0] lvl, input bit rdy, input bit clr);
    chk("evt_valid", 32'(evt_valid), 32'(m_full));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_full) begin
      chk("evt_lane_hold", 32'(evt_lane), 32'(m_lane));
      chk("evt_time_hold", 32'(evt_time), 32'(m_time));
    end
    btn_level = lvl;
    evt_ready = rdy;
    clr_overrun = clr;
    m_step(lvl, rdy, clr);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input bit [N-1:0] lvl, input bit rdy, input bit clr, input int n);
    for (int i = 0; i < n; i++) cyc(lvl, rdy, clr);
  endtask
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (q.size() == 0) chk("evt_unexpected", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("evt_lane", 32'(evt_lane), 32'(e / 256));
          chk("evt_time", 32'(evt_time), 32'(e % 256));
        end
      end
    end
  end
  initial begin : driver
    bit [N-1:0] lvl;
    rst = 1'b1;
    btn_level = '0;
    evt_ready = 1'b0;
    clr_overrun = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run(4'b0000, 1, 0, 10);
    run(4'b0100, 1, 0, 6);
    run(4'b0000, 1, 0, 2);
    run(4'b1011, 1, 0, 6);
    run(4'b0000, 1, 0, 2);
    run(4'b1011, 1, 0, 6);
    run(4'b0000, 1, 0, 3);
    run(4'b0110, 0, 0, 25);
    run(4'b0000, 1, 0, 5);
    run(4'b0001, 0, 0, 2);
    run(4'b0000, 0, 0, 2);
    run(4'b0001, 0, 0, 2);
    run(4'b0000, 0, 0, 2);
    run(4'b0001, 0, 1, 1);
    run(4'b0000, 0, 0, 2);
    run(4'b0000, 0, 1, 1);
    run(4'b0000, 1, 0, 6);
    lvl = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) lvl = lvl ^ 4'($urandom);
      cyc(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    run(4'b0000, 1, 0, 6);
    run(4'b0111, 0, 0, 3);
    run(4'b0000, 0, 0, 2);
    run(4'b0111, 0, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(4'b0111, 0, 0, 4);
    run(4'b0111, 1, 0, 8);
    run(4'b0000, 1, 0, 10);
    chk("q_left", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
